ro_freq_counter: RTL and testbench
==================================

// Module: ro_freq_counter
// PURPOSE
//  Measures the ring-oscillator signal returned by the 16:1 oscillator mux (io_out[0] path).
//  It counts rising edges of ro_in over a programmable gate window of wb_clk_i cycles.
//  It drives the mux select and exposes control and results as a Wishbone slave on the user-project bus.
//  ro_in is sampled synchronously. Valid for f_ro < f_clk/2; faster rings require external pre-division.
// PARAMETERS
//  BASE_ADDR   32'h3000_0000  Wishbone base; decodes wbs_adr_i[31:4]==BASE_ADDR[31:4]
//  CNT_W       24             edge-count width (saturating)
//  GATE_W      24             gate-window length register width
//  GATE_RST    24'd10000      reset value of GATE register
//  SYNC_STAGES 2              synchronizer flops on ro_in (>=2)
//  SETTLE_CYC  8              idle cycles after start before gating (flushes sync, mux settling)
// PORTS
//  wb_clk_i   in   1   sole clock
//  wb_rst_i   in   1   synchronous reset, active-high
//  wbs_cyc_i  in   1   Wishbone cycle
//  wbs_stb_i  in   1   Wishbone strobe
//  wbs_we_i   in   1   1=write
//  wbs_sel_i  in   4   byte lane enables (writes)
//  wbs_adr_i  in   32  byte address; [3:2] selects register
//  wbs_dat_i  in   32  write data
//  wbs_ack_o  out  1   single-cycle acknowledge
//  wbs_dat_o  out  32  read data, valid with ack
//  ro_in      in   1   asynchronous oscillator mux output
//  sel_o      out  4   oscillator mux select (to mux select[3:0])
//  busy_o     out  1   measurement in progress
// BEHAVIOUR
//  Reset: wbs_ack_o=0, wbs_dat_o=0, sel_o=0, busy_o=0, COUNT=0, flags=0, GATE=GATE_RST, FSM=IDLE, sync chain=0.
//  Registers (offset): 0x0 CTRL  [0]start W1 self-clear, [1]continuous, [2]abort W1 self-clear, [7:4]sel
//                      0x4 GATE  [GATE_W-1:0] window length in clocks
//                      0x8 COUNT [CNT_W-1:0] last completed result, RO
//                      0xC STATUS [0]busy RO, [1]done W1C, [2]ovf W1C
//  Bus: access = cyc&stb&decode&!ack. Ack asserts the next cycle for exactly 1 cycle, then drops. Back-to-back accesses ack every other cycle.
//   Writes honour wbs_sel_i per byte. Reads return zero in unused bits. Write data to RO fields is ignored.
//   Non-decoded addresses: no ack. Decoded reads/writes are ack'd regardless of FSM state.
//  Edge detect: rise = sync[SYNC_STAGES-1] & ~prev. Edges are counted only in GATE state.
//  FSM: IDLE   -start-> SETTLE: load settle ctr=SETTLE_CYC, clear edge counter, busy=1.
//       SETTLE -ctr==0-> GATE: load gate ctr=max(GATE,1).
//       GATE   counts rise for exactly max(GATE,1) clocks. The last-cycle edge counts. -> DONE.
//       DONE   (1 cycle) COUNT<=edge count, done=1, ovf|=saturated. -> SETTLE if continuous else IDLE (busy=0).
//  Latency: start write ack cycle + SETTLE_CYC + GATE + 1 clocks until done=1.
//  sel_o updates on CTRL write in any state. A sel change while busy restarts at SETTLE with the edge counter cleared.
//  start while busy: ignored. abort (any state != IDLE): -> IDLE, busy=0, COUNT/done unchanged. abort wins over start in the same write.
//  Edge counter saturates at all-ones. Saturation sets ovf at DONE. No wrap.
//  GATE writes while busy take effect at the next SETTLE->GATE transition.
//  DONE set and W1C done in the same cycle: set wins. Same rule for ovf.
//  Clearing continuous while busy: the current window completes, then IDLE.
//  Reset mid-measurement: all state returns to reset values next edge; no partial COUNT update.
// TESTING
//  1 reset: assert wb_rst_i 2 clk -> read CTRL=0, GATE=10000, COUNT=0, STATUS=0, ack 1 cycle after each stb.
//  2 ro_in = clk/4 square wave, GATE=100, start -> done after 8+100+1 clk, COUNT=25 (+/-1), busy_o low.
//  3 CNT_W=4, ro_in=clk/2, GATE=64 -> COUNT=15, STATUS.ovf=1; W1C 0x6 -> STATUS=0.
//  4 continuous=1, GATE=50, ro_in=clk/5 -> done repeats every 59 clk, COUNT=10 each window; clear continuous -> IDLE after current window.
//  5 start, abort mid-GATE -> busy 0 within 1 clk, COUNT keeps previous value; start while busy -> no restart.
//  6 write CTRL sel=4'hA, sel lane mask 4'b0001 -> sel_o=A; non-decoded addr -> no ack; GATE=0 -> 1-clk window.

Source files
------------

// File: rtl/ro_freq_counter.sv
// ---------------------------------------------------------------------------
// ro_freq_counter
// Ring-oscillator frequency counter with a Wishbone slave register interface.
// Counts rising edges of the (synchronised) ro_in signal over a programmable
// window of wb_clk_i cycles and drives the 16:1 oscillator mux select.
//
// Ports
//   wb_clk_i    sole clock
//   wb_rst_i    synchronous reset, active-high
//   wbs_cyc_i   Wishbone cycle
//   wbs_stb_i   Wishbone strobe
//   wbs_we_i    1 = write
//   wbs_sel_i   byte lane enables for writes
//   wbs_adr_i   byte address, [3:2] selects the register
//   wbs_dat_i   write data
//   wbs_ack_o   single-cycle acknowledge
//   wbs_dat_o   read data, valid with ack
//   ro_in       asynchronous oscillator mux output
//   sel_o       oscillator mux select
//   busy_o      measurement in progress
//
// Register map (offset)
//   0x0 CTRL   [0] start (W1, self-clear) [1] continuous [2] abort (W1,
//              self-clear) [7:4] sel
//   0x4 GATE   window length in clocks (0 behaves as 1)
//   0x8 COUNT  last completed edge count, read-only, saturating
//   0xC STATUS [0] busy RO, [1] done W1C, [2] ovf W1C
// ---------------------------------------------------------------------------
module ro_freq_counter #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          CNT_W       = 24,
    parameter int          GATE_W      = 24,
    parameter int unsigned GATE_RST    = 32'd10000,
    parameter int          SYNC_STAGES = 2,
    parameter int          SETTLE_CYC  = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        ro_in,
    output logic [3:0]  sel_o,
    output logic        busy_o
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1) + 1;
    localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GATE   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [GATE_W-1:0]   gcnt_q, gcnt_d;
    logic [CNT_W-1:0]    ecnt_q, ecnt_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic                cont_q, cont_d;
    logic [3:0]          sel_q, sel_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic                busy_q, busy_d;
    logic                ack_q, ack_d;
    logic [31:0]         rdat_q, rdat_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                prev_q;

    logic        dec_s, acc_s, wr_s, rd_s;
    logic [1:0]  ridx_s;
    logic        ctrl_wr_s, gate_wr_s, stat_wr_s;
    logic        start_s, abort_s, sel_chg_s, rise_s;
    logic [GATE_W-1:0] gate_win_s;
    logic [31:0] gate_new_s;
    logic        unused_ok_s;

    // Bus access qualification: a new access is never accepted in the ack cycle,
    // which is what spaces back-to-back accesses to every other cycle.
    assign dec_s     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign acc_s     = wbs_cyc_i & wbs_stb_i & dec_s & ~ack_q;
    assign wr_s      = acc_s & wbs_we_i;
    assign rd_s      = acc_s & ~wbs_we_i;
    assign ridx_s    = wbs_adr_i[3:2];
    assign ctrl_wr_s = wr_s & (ridx_s == 2'd0) & wbs_sel_i[0];
    assign gate_wr_s = wr_s & (ridx_s == 2'd1);
    assign stat_wr_s = wr_s & (ridx_s == 2'd3) & wbs_sel_i[0];
    assign start_s   = ctrl_wr_s & wbs_dat_i[0];
    assign abort_s   = ctrl_wr_s & wbs_dat_i[2];
    assign sel_chg_s = ctrl_wr_s & (wbs_dat_i[7:4] != sel_q);
    assign rise_s    = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign gate_win_s = (gate_q == '0) ? GATE_W'(1) : gate_q;
    assign unused_ok_s = ^{wbs_adr_i[1:0], gate_new_s};

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;
    assign sel_o     = sel_q;
    assign busy_o    = busy_q;

    // Register-file next state: byte-lane GATE merge, CTRL fields, read mux.
    always_comb begin
        gate_new_s = 32'(gate_q);
        for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) begin
                gate_new_s[8*b +: 8] = wbs_dat_i[8*b +: 8];
            end else begin
                gate_new_s[8*b +: 8] = gate_new_s[8*b +: 8];
            end
        end
        gate_d = gate_wr_s ? gate_new_s[GATE_W-1:0] : gate_q;
        cont_d = ctrl_wr_s ? wbs_dat_i[1]   : cont_q;
        sel_d  = ctrl_wr_s ? wbs_dat_i[7:4] : sel_q;
        ack_d  = acc_s;
        rdat_d = 32'h0000_0000;
        if (rd_s) begin
            case (ridx_s)
                2'd0:    rdat_d = {24'h00_0000, sel_q, 2'b00, cont_q, 1'b0};
                2'd1:    rdat_d = 32'(gate_q);
                2'd2:    rdat_d = 32'(count_q);
                2'd3:    rdat_d = {29'h0000_0000, ovf_q, done_q, busy_q};
                default: rdat_d = 32'h0000_0000;
            endcase
        end else begin
            rdat_d = 32'h0000_0000;
        end
    end

    // Measurement FSM next state. Abort beats a sel change, which beats normal
    // sequencing; in DONE the set of done/ovf is applied after the W1C clear so
    // a simultaneous clear loses.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        gcnt_d   = gcnt_q;
        ecnt_d   = ecnt_q;
        count_d  = count_q;
        done_d   = done_q & ~(stat_wr_s & wbs_dat_i[1]);
        ovf_d    = ovf_q  & ~(stat_wr_s & wbs_dat_i[2]);
        if ((state_q != ST_IDLE) && abort_s) begin
            state_d = ST_IDLE;
        end else if ((state_q != ST_IDLE) && sel_chg_s) begin
            state_d  = ST_SETTLE;
            settle_d = SETTLE_LD;
            ecnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s && !abort_s) begin
                        state_d  = ST_SETTLE;
                        settle_d = SETTLE_LD;
                        ecnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    // settle_q holds the SETTLE cycles still to spend, this one included
                    if (settle_q <= SET_W'(1)) begin
                        state_d = ST_GATE;
                        gcnt_d  = gate_win_s;
                    end else begin
                        settle_d = settle_q - SET_W'(1);
                    end
                end
                ST_GATE: begin
                    if (rise_s && (ecnt_q != CNT_MAX)) begin
                        ecnt_d = ecnt_q + CNT_W'(1);
                    end else begin
                        ecnt_d = ecnt_q;
                    end
                    if (gcnt_q <= GATE_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        gcnt_d = gcnt_q - GATE_W'(1);
                    end
                end
                ST_DONE: begin
                    count_d = ecnt_q;
                    done_d  = 1'b1;
                    ovf_d   = ovf_d | (ecnt_q == CNT_MAX);
                    if (cont_q) begin
                        state_d  = ST_SETTLE;
                        settle_d = SETTLE_LD;
                        ecnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
        sync_d = {sync_q[SYNC_STAGES-2:0], ro_in};
    end

    // State and register update with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            gcnt_q   <= '0;
            ecnt_q   <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cont_q   <= 1'b0;
            sel_q    <= 4'h0;
            gate_q   <= GATE_W'(GATE_RST);
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            rdat_q   <= 32'h0000_0000;
            sync_q   <= '0;
            prev_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            gcnt_q   <= gcnt_d;
            ecnt_q   <= ecnt_d;
            count_q  <= count_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            cont_q   <= cont_d;
            sel_q    <= sel_d;
            gate_q   <= gate_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            rdat_q   <= rdat_d;
            sync_q   <= sync_d;
            prev_q   <= sync_q[SYNC_STAGES-1];
        end
    end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Testbench for ro_freq_counter: bus tasks issue stimulus and queue the
// expected read data / busy-fall cycles; a monitor process compares them.
module tb_ro_freq_counter;

    localparam int unsigned SETTLE = 8;
    localparam int unsigned CMAX   = 255;
    localparam logic [31:0] BASE   = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        ro_in;
    logic [3:0]  sel_o;
    logic        busy;

    ro_freq_counter #(.CNT_W(8)) dut (
        .wb_clk_i (clk),  .wb_rst_i (rst),
        .wbs_cyc_i(cyc),  .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel),  .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack),  .wbs_dat_o(rdat),
        .ro_in    (ro_in), .sel_o   (sel_o), .busy_o (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Periodic square wave of ro_per clocks, changing shortly after the clock edge
    int unsigned ro_per = 4, ro_ph = 0;
    initial begin
        ro_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            ro_in = (((cyc_cnt + ro_ph) % ro_per) < (ro_per / 2));
        end
    end

    typedef struct {string nm; logic [31:0] lo; logic [31:0] hi; bit chk_sel; logic [3:0] sel;} rd_exp_t;
    typedef struct {string nm; int unsigned cyc; bit at_ack; int unsigned dl;} busy_exp_t;
    rd_exp_t   rdq[$];
    busy_exp_t bq[$];
    int n_chk = 0, n_pass = 0;
    logic [3:0] cur_sel = 4'h0;

    function automatic void chk(string nm, bit ok, longint act, longint lo, longint hi);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %0d, required %0d..%0d", nm, act, lo, hi);
    endfunction

    // Monitor: bus protocol, read data and busy-fall timing
    initial begin
        bit prev_req, prev_dec, prev_busy;
        int unsigned last_ack, expc;
        rd_exp_t e;
        busy_exp_t b;
        prev_req = 0; prev_dec = 0; prev_busy = 0; last_ack = 0;
        forever begin
            @(negedge clk);
            if (prev_req)
                chk(prev_dec ? "ack_after_access" : "no_ack_undecoded", ack == prev_dec, ack, prev_dec, prev_dec);
            else if (ack)
                chk("spurious_ack", 1'b0, ack, 0, 0);
            if (ack) begin
                last_ack = cyc_cnt;
                if (!we) begin
                    if (rdq.size() == 0) chk("unexpected_read", 1'b0, rdat, 0, 0);
                    else begin
                        e = rdq.pop_front();
                        chk(e.nm, (rdat >= e.lo) && (rdat <= e.hi), rdat, e.lo, e.hi);
                        if (e.chk_sel) chk("sel_o", sel_o == e.sel, sel_o, e.sel, e.sel);
                    end
                end
            end
            if (prev_busy && !busy) begin
                if (bq.size() == 0) chk("unexpected_busy_fall", 1'b0, cyc_cnt, 0, 0);
                else begin
                    b = bq.pop_front();
                    expc = b.at_ack ? last_ack : b.cyc;
                    chk(b.nm, cyc_cnt == expc, cyc_cnt, expc, expc);
                end
            end else if ((bq.size() > 0) && (cyc_cnt > bq[0].dl)) begin
                b = bq.pop_front();
                chk({b.nm, "_timeout"}, 1'b0, cyc_cnt, b.cyc, b.cyc);
            end
            prev_req  = cyc & stb & ~ack;
            prev_dec  = (adr[31:4] == 28'h300_0000);
            prev_busy = busy;
        end
    end

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int max_wait, output int unsigned ack_cyc);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        ack_cyc = 0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (ack) begin
                ack_cyc = cyc_cnt;
                break;
            end
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] off, input string nm, input logic [31:0] lo, input logic [31:0] hi);
        int unsigned t;
        rdq.push_back('{nm, lo, hi, (off == 32'h0), cur_sel});
        xfer(1'b0, BASE | off, 32'h0, 4'hF, 4, t);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s, output int unsigned ac);
        xfer(1'b1, BASE | off, d, s, 4, ac);
    endtask

    function automatic logic [31:0] ctrl(bit start, bit cont, bit abrt);
        return {24'h0, cur_sel, 1'b0, abrt, cont, start};
    endfunction

    task automatic expect_fall(input string nm, input int unsigned c);
        bq.push_back('{nm, c, 1'b0, c + 20});
    endtask

    task automatic wait_idle();
        while (bq.size() > 0) @(negedge clk);
    endtask

    // Program GATE, clear status, and start; returns the start ack cycle
    task automatic start_meas(input int unsigned g, input int unsigned p, input bit cont, output int unsigned c0);
        int unsigned t;
        ro_per = p;
        ro_ph  = $urandom_range(p - 1, 0);
        wr(32'h4, g, 4'hF, t);
        wr(32'hC, 32'h6, 4'h1, t);
        wr(32'h0, ctrl(1'b1, cont, 1'b0), 4'h1, c0);
    endtask

    // One-shot measurement with expected count from window length / period
    task automatic run_single(input string nm, input int unsigned g, input int unsigned p);
        int unsigned c0, gw, lo, hi;
        bit sat;
        start_meas(g, p, 1'b0, c0);
        gw = (g == 0) ? 1 : g;
        expect_fall({nm, "_busy_fall"}, c0 + SETTLE + gw + 1);
        wait_idle();
        lo = gw / p;
        hi = (gw + p - 1) / p;
        sat = (lo >= CMAX);
        if (lo > CMAX) lo = CMAX;
        if (hi > CMAX) hi = CMAX;
        rd(32'h8, {nm, "_count"}, lo, hi);
        rd(32'hC, {nm, "_status"}, sat ? 32'h6 : 32'h2, sat ? 32'h6 : 32'h2);
    endtask

    initial begin
        int unsigned t, c0, c1, c2;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        rd(32'h0, "rst_ctrl",   32'h0, 32'h0);
        rd(32'h4, "rst_gate",   32'd10000, 32'd10000);
        rd(32'h8, "rst_count",  32'h0, 32'h0);
        rd(32'hC, "rst_status", 32'h0, 32'h0);

        // Byte lanes, address decode, sel lane
        wr(32'h4, 32'h0, 4'hF, t);
        wr(32'h4, 32'hFFFF_ABFF, 4'b0010, t);
        rd(32'h4, "gate_lane", 32'h0000_AB00, 32'h0000_AB00);
        xfer(1'b1, BASE + 32'h14, 32'h5, 4'hF, 3, t);
        rd(32'h4, "gate_after_undecoded", 32'h0000_AB00, 32'h0000_AB00);
        wr(32'h0, 32'hFFFF_FFA0, 4'b0001, t);
        cur_sel = 4'hA;
        rd(32'h0, "ctrl_sel_a", 32'hA0, 32'hA0);

        // Basic measurement and randomized windows / periods
        run_single("clk_div4", 100, 4);
        for (int i = 0; i < 6; i++)
            run_single("rand", $urandom_range(150, 0), $urandom_range(9, 3));
        run_single("gate_zero", 0, 3);

        // Saturation and W1C
        run_single("saturate", 600, 2);
        wr(32'hC, 32'h6, 4'h1, t);
        rd(32'hC, "status_w1c", 32'h0, 32'h0);

        // Abort mid-GATE keeps previous COUNT and done
        start_meas(200, 4, 1'b0, c0);
        while (cyc_cnt < c0 + SETTLE + 50) @(negedge clk);
        bq.push_back('{"abort_busy_fall", 0, 1'b1, cyc_cnt + 20});
        wr(32'h0, ctrl(1'b0, 1'b0, 1'b1), 4'h1, t);
        wait_idle();
        rd(32'h8, "abort_count_kept", CMAX, CMAX);
        rd(32'hC, "abort_status", 32'h0, 32'h0);

        // Start while busy is ignored
        start_meas(60, 4, 1'b0, c1);
        expect_fall("restart_ignored_fall", c1 + SETTLE + 61);
        wr(32'h0, ctrl(1'b1, 1'b0, 1'b0), 4'h1, t);
        wait_idle();
        rd(32'h8, "restart_ignored_count", 15, 15);
        rd(32'hC, "restart_ignored_status", 32'h2, 32'h2);

        // sel change while busy restarts at SETTLE
        start_meas(40, 5, 1'b0, c1);
        while (cyc_cnt < c1 + SETTLE + 20) @(negedge clk);
        cur_sel = cur_sel ^ 4'h1;
        wr(32'h0, ctrl(1'b0, 1'b0, 1'b0), 4'h1, c2);
        expect_fall("sel_restart_fall", c2 + SETTLE + 41);
        wait_idle();
        rd(32'h8, "sel_restart_count", 8, 8);
        rd(32'h0, "sel_restart_ctrl", {24'h0, cur_sel, 4'h0}, {24'h0, cur_sel, 4'h0});

        // Continuous mode: 59-clock period, clear mid third window
        start_meas(50, 5, 1'b1, c0);
        while (cyc_cnt < c0 + 2 * 59 + 20) @(negedge clk);
        wr(32'h0, ctrl(1'b0, 1'b0, 1'b0), 4'h1, t);
        expect_fall("cont_stop_fall", c0 + 3 * 59);
        wait_idle();
        rd(32'h8, "cont_count", 10, 10);
        rd(32'hC, "cont_status", 32'h2, 32'h2);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
